// File: rtl/rs232_echo_master.sv
// Polls an RS232 UART over Avalon-MM and echoes received bytes back,
// buffering them in a small FIFO while the transmitter has no space.
module rs232_echo_master #(
    parameter int FIFO_DEPTH = 8,
    parameter bit UPPERCASE  = 1'b0
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        enable,
    output logic        avm_address,
    output logic        avm_chipselect,
    output logic [3:0]  avm_byteenable,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    output logic [15:0] rx_count,
    output logic [15:0] tx_count,
    output logic        busy
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_DATA, S_WAIT_DATA, S_RD_CTRL, S_WAIT_CTRL, S_WR_DATA
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_cnt;
    logic [15:0]   r_rx_count;
    logic [15:0]   r_tx_count;

    logic        r_read;
    logic        r_write;
    logic        r_cs;
    logic        r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wd;

    logic        w_read;
    logic        w_write;
    logic        w_cs;
    logic        w_addr;
    logic [3:0]  w_be;
    logic [31:0] w_wd;

    logic       w_full;
    logic       w_empty;
    logic       w_push;
    logic       w_pop;
    logic       w_is_lower;
    logic [7:0] w_push_byte;
    logic       w_unused;

    assign w_full     = (r_cnt == (AW+1)'(FIFO_DEPTH));
    assign w_empty    = (r_cnt == '0);
    assign w_push     = (r_state == S_WAIT_DATA) && avm_readdata[15];
    assign w_pop      = (r_state == S_WR_DATA);
    assign w_is_lower = (avm_readdata[7:0] >= 8'h61) && (avm_readdata[7:0] <= 8'h7A);
    assign w_unused   = &{1'b0, avm_readdata[14:8]};

    always_comb begin
        w_push_byte = avm_readdata[7:0];
        if (UPPERCASE && w_is_lower) begin
            w_push_byte = avm_readdata[7:0] - 8'h20;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:      if (enable) w_next = w_full ? S_RD_CTRL : S_RD_DATA;
            S_RD_DATA:   w_next = S_WAIT_DATA;
            S_WAIT_DATA: w_next = S_RD_CTRL;
            S_RD_CTRL:   w_next = S_WAIT_CTRL;
            S_WAIT_CTRL: w_next = (avm_readdata[31:16] != 16'h0 && !w_empty)
                                  ? S_WR_DATA : S_IDLE;
            S_WR_DATA:   w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they register on entry.
    always_comb begin
        w_read  = 1'b0;
        w_write = 1'b0;
        w_cs    = 1'b0;
        w_addr  = 1'b0;
        w_be    = 4'h0;
        w_wd    = 32'h0;
        unique case (w_next)
            S_RD_DATA: begin
                w_read = 1'b1;
                w_cs   = 1'b1;
                w_be   = 4'b1111;
            end
            S_RD_CTRL: begin
                w_read = 1'b1;
                w_cs   = 1'b1;
                w_addr = 1'b1;
                w_be   = 4'b1111;
            end
            S_WR_DATA: begin
                w_write = 1'b1;
                w_cs    = 1'b1;
                w_be    = 4'b0001;
                w_wd    = {24'h0, r_mem[r_rptr]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_cs    <= 1'b0;
            r_addr  <= 1'b0;
            r_be    <= 4'h0;
            r_wd    <= 32'h0;
        end else begin
            r_read  <= w_read;
            r_write <= w_write;
            r_cs    <= w_cs;
            r_addr  <= w_addr;
            r_be    <= w_be;
            r_wd    <= w_wd;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_push_byte;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_cnt      <= '0;
            r_rx_count <= 16'h0;
            r_tx_count <= 16'h0;
        end else begin
            if (w_push) begin
                r_wptr     <= r_wptr + AW'(1);
                r_cnt      <= r_cnt + (AW+1)'(1);
                r_rx_count <= r_rx_count + 16'h1;
            end
            if (w_pop) begin
                r_rptr     <= r_rptr + AW'(1);
                r_cnt      <= r_cnt - (AW+1)'(1);
                r_tx_count <= r_tx_count + 16'h1;
            end
        end
    end

    assign avm_read       = r_read;
    assign avm_write      = r_write;
    assign avm_chipselect = r_cs;
    assign avm_address    = r_addr;
    assign avm_byteenable = r_be;
    assign avm_writedata  = r_wd;
    assign rx_count       = r_rx_count;
    assign tx_count       = r_tx_count;
    assign busy           = (r_state != S_IDLE);

endmodule
